// File: rtl/uc_multicycle.sv
// Multicycle control unit: FETCH/DECODE/EXEC sequencing with a bounded
// return stack and a data-memory handshake that faults on timeout.
module uc_multicycle #(
    parameter int STACK_DEPTH = 8,
    parameter int SPW         = $clog2(STACK_DEPTH + 1),
    parameter int ALUW        = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      opcode,
    input  logic            z,
    input  logic            mem_ready,
    output logic            s_inc,
    output logic            s_inm,
    output logic            s_pila,
    output logic            s_data,
    output logic            we3,
    output logic            wez,
    output logic            we4,
    output logic            push,
    output logic            pop,
    output logic [ALUW-1:0] op_alu,
    output logic            ir_we,
    output logic            pc_we,
    output logic            mem_req,
    output logic [SPW-1:0]  sp,
    output logic            fault,
    output logic            busy
);

    typedef enum logic [2:0] {
        START,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        FAULT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;

    logic is_arith, is_ext, is_legal;
    logic is_ldi, is_jmp, is_jz, is_jnz, is_push, is_pop, is_lw, is_sw;
    logic stack_full, stack_empty;

    assign is_arith = ~opcode[5];
    assign is_ext   = (opcode[5:3] == 3'b100);
    assign is_legal = is_arith | is_ext;
    assign is_ldi   = is_ext && (opcode[2:0] == 3'd0);
    assign is_jmp   = is_ext && (opcode[2:0] == 3'd1);
    assign is_jz    = is_ext && (opcode[2:0] == 3'd2);
    assign is_jnz   = is_ext && (opcode[2:0] == 3'd3);
    assign is_push  = is_ext && (opcode[2:0] == 3'd4);
    assign is_pop   = is_ext && (opcode[2:0] == 3'd5);
    assign is_lw    = is_ext && (opcode[2:0] == 3'd6);
    assign is_sw    = is_ext && (opcode[2:0] == 3'd7);

    assign stack_full  = (sp == SPW'(STACK_DEPTH));
    assign stack_empty = (sp == '0);

    assign fault = (state == FAULT);
    assign busy  = (state != START) && (state != FAULT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= START;
        end else begin
            state <= state_next;
        end
    end

    // Stack pointer only moves on the EXEC cycle; DECODE has already
    // diverted overflow/underflow to FAULT, the guards just forbid wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp <= '0;
        end else if (push && !stack_full) begin
            sp <= sp + SPW'(1);
        end else if (pop && !stack_empty) begin
            sp <= sp - SPW'(1);
        end
    end

    // Wait counter is held at zero outside MEM, so it starts clean on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state != MEM) begin
            wait_cnt <= '0;
        end else if (!mem_ready && (wait_cnt != 8'hFF)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        s_inc      = 1'b0;
        s_inm      = 1'b0;
        s_pila     = 1'b0;
        s_data     = 1'b0;
        we3        = 1'b0;
        wez        = 1'b0;
        we4        = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        op_alu     = '0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        mem_req    = 1'b0;

        case (state)
            START: begin
                state_next = FETCH;
            end
            FETCH: begin
                ir_we      = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                if (!is_legal) begin
                    state_next = FAULT;
                end else if (is_lw || is_sw) begin
                    state_next = MEM;
                end else if ((is_push && stack_full) || (is_pop && stack_empty)) begin
                    state_next = FAULT;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                pc_we      = 1'b1;
                state_next = FETCH;
                if (is_arith) begin
                    op_alu = opcode[1+ALUW:2];
                    we3    = 1'b1;
                    wez    = 1'b1;
                    s_inc  = 1'b1;
                end else if (is_ldi) begin
                    s_inm = 1'b1;
                    we3   = 1'b1;
                    s_inc = 1'b1;
                end else if (is_jz) begin
                    s_inc = ~z;
                end else if (is_jnz) begin
                    s_inc = z;
                end else if (is_push) begin
                    push  = 1'b1;
                    s_inc = 1'b1;
                end else if (is_pop) begin
                    pop    = 1'b1;
                    s_pila = 1'b1;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                s_data  = 1'b1;
                s_inm   = 1'b1;
                // Completion is checked first so a late mem_ready beats the timeout.
                if (mem_ready) begin
                    we3        = is_lw;
                    we4        = is_sw;
                    pc_we      = 1'b1;
                    s_inc      = 1'b1;
                    state_next = FETCH;
                end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
                    state_next = FAULT;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = START;
            end
        endcase
    end

endmodule

// File: tb/tb_uc_multicycle.sv
// Directed bench for uc_multicycle (STACK_DEPTH=2) with hand-computed
// per-state control vectors.
module tb_uc_multicycle;

    localparam int TB_DEPTH = 2;
    localparam int TB_SPW   = $clog2(TB_DEPTH + 1);

    localparam logic [13:0] B_SINC  = 14'h2000;
    localparam logic [13:0] B_SINM  = 14'h1000;
    localparam logic [13:0] B_SPILA = 14'h0800;
    localparam logic [13:0] B_SDATA = 14'h0400;
    localparam logic [13:0] B_WE3   = 14'h0200;
    localparam logic [13:0] B_WEZ   = 14'h0100;
    localparam logic [13:0] B_WE4   = 14'h0080;
    localparam logic [13:0] B_PUSH  = 14'h0040;
    localparam logic [13:0] B_POP   = 14'h0020;
    localparam logic [13:0] B_IRWE  = 14'h0010;
    localparam logic [13:0] B_PCWE  = 14'h0008;
    localparam logic [13:0] B_MREQ  = 14'h0004;
    localparam logic [13:0] B_FAULT = 14'h0002;
    localparam logic [13:0] B_BUSY  = 14'h0001;

    localparam logic [13:0] C_FETCH = B_IRWE | B_BUSY;
    localparam logic [13:0] C_MWAIT = B_MREQ | B_SDATA | B_SINM | B_BUSY;

    logic              clk = 1'b0;
    logic              reset;
    logic [5:0]        opcode;
    logic              z;
    logic              mem_ready;
    logic              s_inc, s_inm, s_pila, s_data;
    logic              we3, wez, we4, push, pop;
    logic [2:0]        op_alu;
    logic              ir_we, pc_we, mem_req;
    logic [TB_SPW-1:0] sp;
    logic              fault, busy;
    logic [13:0]       ctl;

    int total = 0;
    int bad   = 0;

    uc_multicycle #(.STACK_DEPTH(TB_DEPTH), .ALUW(3), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .mem_ready(mem_ready),
        .s_inc(s_inc), .s_inm(s_inm), .s_pila(s_pila), .s_data(s_data),
        .we3(we3), .wez(wez), .we4(we4), .push(push), .pop(pop),
        .op_alu(op_alu), .ir_we(ir_we), .pc_we(pc_we), .mem_req(mem_req),
        .sp(sp), .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    assign ctl = {s_inc, s_inm, s_pila, s_data, we3, wez, we4, push, pop,
                  ir_we, pc_we, mem_req, fault, busy};

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT one cycle into FETCH, 1 time unit past the edge.
    task automatic resetDut();
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        checkOutput("rst_ctl", 32'(ctl), 32'h0);
        checkOutput("rst_sp", 32'(sp), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("start_ctl", 32'(ctl), 32'h0);
        tick();
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic zv, input logic [13:0] exp_exec,
                                 input logic [2:0] exp_alu, input string tag);
        opcode = op;
        z      = zv;
        #1;
        checkOutput({tag, "_fetch"}, 32'(ctl), 32'(C_FETCH));
        tick();
        #1;
        checkOutput({tag, "_decode"}, 32'(ctl), 32'(B_BUSY));
        tick();
        #1;
        checkOutput({tag, "_exec"}, 32'(ctl), 32'(exp_exec));
        checkOutput({tag, "_alu"}, 32'(op_alu), 32'(exp_alu));
        tick();
    endtask

    task automatic memInstr(input logic [5:0] op, input int n_low, input bit complete,
                            input logic [13:0] exp_done, input int exp_cycles, input string tag);
        int cyc  = 0;
        int mreq = 0;
        opcode    = op;
        mem_ready = 1'b1;
        #1;
        checkOutput({tag, "_fetch"}, 32'(ctl), 32'(C_FETCH));
        tick(); cyc++;
        #1;
        checkOutput({tag, "_decode"}, 32'(ctl), 32'(B_BUSY));
        tick(); cyc++;
        for (int i = 0; i < n_low; i++) begin
            mem_ready = 1'b0;
            #1;
            checkOutput({tag, "_wait"}, 32'(ctl), 32'(C_MWAIT));
            mreq += int'(mem_req);
            tick(); cyc++;
        end
        if (complete) begin
            mem_ready = 1'b1;
            #1;
            checkOutput({tag, "_done"}, 32'(ctl), 32'(exp_done));
            mreq += int'(mem_req);
            tick(); cyc++;
            mem_ready = 1'b0;
            #1;
            checkOutput({tag, "_next_fetch"}, 32'(ctl), 32'(C_FETCH));
            checkOutput({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
            checkOutput({tag, "_mreq_cycles"}, 32'(mreq), 32'(n_low + 1));
        end else begin
            mem_ready = 1'b0;
            #1;
            checkOutput({tag, "_timeout"}, 32'(ctl), 32'(B_FAULT));
            checkOutput({tag, "_mreq_cycles"}, 32'(mreq), 32'(n_low));
        end
    endtask

    task automatic faultInstr(input logic [5:0] op, input logic [TB_SPW-1:0] exp_sp, input string tag);
        opcode = op;
        #1;
        checkOutput({tag, "_fetch"}, 32'(ctl), 32'(C_FETCH));
        tick();
        #1;
        checkOutput({tag, "_decode"}, 32'(ctl), 32'(B_BUSY));
        tick();
        #1;
        checkOutput({tag, "_fault"}, 32'(ctl), 32'(B_FAULT));
        checkOutput({tag, "_sp"}, 32'(sp), 32'(exp_sp));
        mem_ready = 1'b1;
        tick();
        tick();
        #1;
        checkOutput({tag, "_hold"}, 32'(ctl), 32'(B_FAULT));
        mem_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        opcode    = 6'd0;
        z         = 1'b0;
        mem_ready = 1'b0;

        resetDut();
        applyStimulus(6'b010100, 1'b0, B_WE3 | B_WEZ | B_SINC | B_PCWE | B_BUSY, 3'b101, "arith");
        applyStimulus(6'b001000, 1'b1, B_WE3 | B_WEZ | B_SINC | B_PCWE | B_BUSY, 3'b010, "arith2");
        applyStimulus(6'b100010, 1'b1, B_PCWE | B_BUSY, 3'b000, "jz_taken");
        applyStimulus(6'b100010, 1'b0, B_SINC | B_PCWE | B_BUSY, 3'b000, "jz_not");
        applyStimulus(6'b100011, 1'b1, B_SINC | B_PCWE | B_BUSY, 3'b000, "jnz_z1");
        applyStimulus(6'b100011, 1'b0, B_PCWE | B_BUSY, 3'b000, "jnz_z0");
        applyStimulus(6'b100000, 1'b0, B_SINM | B_WE3 | B_SINC | B_PCWE | B_BUSY, 3'b000, "ldi");
        applyStimulus(6'b100001, 1'b0, B_PCWE | B_BUSY, 3'b000, "jmp");
        applyStimulus(6'b100100, 1'b0, B_PUSH | B_SINC | B_PCWE | B_BUSY, 3'b000, "push1");
        checkOutput("sp_after_push1", 32'(sp), 32'd1);
        applyStimulus(6'b100100, 1'b0, B_PUSH | B_SINC | B_PCWE | B_BUSY, 3'b000, "push2");
        checkOutput("sp_after_push2", 32'(sp), 32'd2);
        applyStimulus(6'b100101, 1'b0, B_POP | B_SPILA | B_PCWE | B_BUSY, 3'b000, "pop1");
        checkOutput("sp_after_pop1", 32'(sp), 32'd1);
        applyStimulus(6'b100101, 1'b0, B_POP | B_SPILA | B_PCWE | B_BUSY, 3'b000, "pop2");
        checkOutput("sp_after_pop2", 32'(sp), 32'd0);

        memInstr(6'b100110, 4, 1'b1, C_MWAIT | B_WE3 | B_PCWE | B_SINC, 7, "lw4");
        memInstr(6'b100111, 15, 1'b1, C_MWAIT | B_WE4 | B_PCWE | B_SINC, 18, "sw_late");
        memInstr(6'b100111, 16, 1'b0, 14'h0, 0, "sw_timeout");

        resetDut();
        applyStimulus(6'b100100, 1'b0, B_PUSH | B_SINC | B_PCWE | B_BUSY, 3'b000, "ovf_push1");
        checkOutput("ovf_sp1", 32'(sp), 32'd1);
        applyStimulus(6'b100100, 1'b0, B_PUSH | B_SINC | B_PCWE | B_BUSY, 3'b000, "ovf_push2");
        checkOutput("ovf_sp2", 32'(sp), 32'd2);
        faultInstr(6'b100100, 2'd2, "ovf_push3");

        resetDut();
        faultInstr(6'b100101, 2'd0, "pop_empty");

        resetDut();
        faultInstr(6'b111111, 2'd0, "illegal_3f");
        checkOutput("illegal_fault_bit", 32'(fault), 32'd1);
        checkOutput("illegal_busy_bit", 32'(busy), 32'd0);

        resetDut();
        faultInstr(6'b101000, 2'd0, "illegal_28");

        // Reset dropped in the middle of a load, with mem_ready high at that moment.
        resetDut();
        opcode    = 6'b100110;
        mem_ready = 1'b0;
        tick();
        tick();
        #1;
        checkOutput("midmem_wait", 32'(ctl), 32'(C_MWAIT));
        tick();
        mem_ready = 1'b1;
        reset     = 1'b0;
        #1;
        checkOutput("midmem_rst_ctl", 32'(ctl), 32'h0);
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b0;
        #1;
        checkOutput("midmem_start", 32'(ctl), 32'h0);
        tick();
        checkOutput("midmem_refetch", 32'(ctl), 32'(C_FETCH));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
